// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
//   Bundles the two requester command/response channels, the mem-side bus
//   and the busy flag of mem_arbiter.
//   Modports:
//     slave  - the arbiter: takes commands and mem_rd_data, drives ready,
//              responses, the mem command bus and busy.
//     master - the environment (requesters plus mem): the mirror image.
//   Signals:
//     reqN_valid/ready/rd_wr/addr/wr_data  command channel of requester N
//     rspN_valid/data                      read response of requester N
//     mem_enable/rd_wr/addr/wr_data        registered command to mem
//     mem_rd_data                          read data returned by mem
//     busy                                 arbiter not in IDLE
// ---------------------------------------------------------------------------
interface mem_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  req0_valid;
  logic                  req0_ready;
  logic                  req0_rd_wr;
  logic [ADDR_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0] req0_wr_data;
  logic                  rsp0_valid;
  logic [DATA_WIDTH-1:0] rsp0_data;

  logic                  req1_valid;
  logic                  req1_ready;
  logic                  req1_rd_wr;
  logic [ADDR_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0] req1_wr_data;
  logic                  rsp1_valid;
  logic [DATA_WIDTH-1:0] rsp1_data;

  logic                  mem_enable;
  logic                  mem_rd_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [DATA_WIDTH-1:0] mem_rd_data;

  logic                  busy;

  modport slave (
    input  req0_valid, req0_rd_wr, req0_addr, req0_wr_data,
    output req0_ready, rsp0_valid, rsp0_data,
    input  req1_valid, req1_rd_wr, req1_addr, req1_wr_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output mem_enable, mem_rd_wr, mem_addr, mem_wr_data,
    input  mem_rd_data,
    output busy
  );

  modport master (
    output req0_valid, req0_rd_wr, req0_addr, req0_wr_data,
    input  req0_ready, rsp0_valid, rsp0_data,
    output req1_valid, req1_rd_wr, req1_addr, req1_wr_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  mem_enable, mem_rd_wr, mem_addr, mem_wr_data,
    output mem_rd_data,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-port round-robin arbiter/sequencer in front of a single-port memory.
//   Accepts one command at a time from requester 0 or 1, issues it on the
//   registered mem bus for one cycle and, for reads, waits the fixed mem
//   latency and returns the data to the requester that issued the read.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    mem_arbiter_if.slave (command, response, mem bus, busy)
//   Parameters:
//     DATA_WIDTH  data width, must match mem
//     ADDR_WIDTH  address width, must match mem
//     RD_LATENCY  edges from the mem enable edge to valid mem_rd_data (>=1)
// ---------------------------------------------------------------------------
module mem_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int RD_LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(RD_LATENCY) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  prio_q, prio_d;    // port that wins when both are valid
  logic                  owner_q, owner_d;  // port that issued the command in flight
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  mem_enable_q, mem_enable_d;
  logic                  mem_rd_wr_q, mem_rd_wr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wr_data_q, mem_wr_data_d;
  logic                  rsp0_valid_q, rsp0_valid_d;
  logic                  rsp1_valid_q, rsp1_valid_d;
  logic [DATA_WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [DATA_WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic                  busy_q, busy_d;

  logic grant0, grant1;

  // Grant is combinational so a requester is accepted in the same cycle it
  // wins; it is suppressed during reset so no command slips past a reset edge.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE && !reset) begin
      grant0 = bus.req0_valid && (!bus.req1_valid || !prio_q);
      grant1 = bus.req1_valid && (!bus.req0_valid ||  prio_q);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    prio_d        = prio_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    mem_enable_d  = 1'b0;
    mem_rd_wr_d   = mem_rd_wr_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp0_valid_d  = 1'b0;
    rsp1_valid_d  = 1'b0;
    rsp0_data_d   = rsp0_data_q;
    rsp1_data_d   = rsp1_data_q;

    unique case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          // The command is latched straight into the mem bus registers, so
          // it appears on mem_* in the cycle after the accept edge.
          mem_enable_d  = 1'b1;
          mem_rd_wr_d   = grant1 ? bus.req1_rd_wr   : bus.req0_rd_wr;
          mem_addr_d    = grant1 ? bus.req1_addr    : bus.req0_addr;
          mem_wr_data_d = grant1 ? bus.req1_wr_data : bus.req0_wr_data;
          owner_d       = grant1;
          prio_d        = !grant1;  // favour the other port next time
          state_d       = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_rd_wr_q) begin
          cnt_d   = CNT_W'(RD_LATENCY - 1);
          state_d = RD_WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = bus.mem_rd_data;
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = bus.mem_rd_data;
          end
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // value of the others, independent of statement order.
    if (reset) begin
      state_q       <= IDLE;
      prio_q        <= 1'b0;
      owner_q       <= 1'b0;
      cnt_q         <= '0;
      mem_enable_q  <= 1'b0;
      mem_rd_wr_q   <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_data_q   <= '0;
      rsp1_data_q   <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      mem_enable_q  <= mem_enable_d;
      mem_rd_wr_q   <= mem_rd_wr_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp0_data_q   <= rsp0_data_d;
      rsp1_data_q   <= rsp1_data_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.rsp0_valid  = rsp0_valid_q;
  assign bus.rsp0_data   = rsp0_data_q;
  assign bus.rsp1_valid  = rsp1_valid_q;
  assign bus.rsp1_data   = rsp1_data_q;
  assign bus.mem_enable  = mem_enable_q;
  assign bus.mem_rd_wr   = mem_rd_wr_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wr_data = mem_wr_data_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Drives mem_arbiter (RD_LATENCY=2) from two command queues, models the mem
//   block behind it, and compares every cycle against a transaction-level
//   timeline model. A second instance with RD_LATENCY=3 is exercised with a
//   directed write/read sequence.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int LAT_A = 2;
  localparam int LAT_B = 3;

  typedef struct packed {
    logic          rd_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
  } cmd_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifa ();
  mem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifb ();

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa)
  );
  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT_B)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic cmd_t mk(input logic rd_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    cmd_t c;
    c.rd_wr = rd_wr;
    c.addr  = addr;
    c.wd    = wd;
    return c;
  endfunction

  // ---------------- mem models (reset fills contents with 8'hFF) ----------
  logic [DW-1:0] mem_a  [1<<AW];
  logic [DW-1:0] pipe_a [LAT_A];
  logic [DW-1:0] mem_b  [1<<AW];
  logic [DW-1:0] pipe_b [LAT_B];

  always @(posedge clk) begin
    if (reset) begin
      foreach (mem_a[i])  mem_a[i]  <= '1;
      foreach (pipe_a[i]) pipe_a[i] <= '0;
    end else begin
      if (ifa.mem_enable && !ifa.mem_rd_wr) mem_a[ifa.mem_addr] <= ifa.mem_wr_data;
      if (ifa.mem_enable &&  ifa.mem_rd_wr) pipe_a[0] <= mem_a[ifa.mem_addr];
      for (int i = 1; i < LAT_A; i++) pipe_a[i] <= pipe_a[i-1];
    end
  end
  assign ifa.mem_rd_data = pipe_a[LAT_A-1];

  always @(posedge clk) begin
    if (reset) begin
      foreach (mem_b[i])  mem_b[i]  <= '1;
      foreach (pipe_b[i]) pipe_b[i] <= '0;
    end else begin
      if (ifb.mem_enable && !ifb.mem_rd_wr) mem_b[ifb.mem_addr] <= ifb.mem_wr_data;
      if (ifb.mem_enable &&  ifb.mem_rd_wr) pipe_b[0] <= mem_b[ifb.mem_addr];
      for (int i = 1; i < LAT_B; i++) pipe_b[i] <= pipe_b[i-1];
    end
  end
  assign ifb.mem_rd_data = pipe_b[LAT_B-1];

  // ---------------- requester driver for instance A ------------------------
  cmd_t q0[$];
  cmd_t q1[$];
  bit   hs0 = 1'b0;
  bit   hs1 = 1'b0;

  // Each requester presents the head of its queue and holds it until the
  // handshake seen in the previous cycle retires it.
  always @(posedge clk) begin
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    ifa.req0_valid = (q0.size() > 0);
    ifa.req1_valid = (q1.size() > 0);
    if (q0.size() > 0) begin
      ifa.req0_rd_wr = q0[0].rd_wr; ifa.req0_addr = q0[0].addr; ifa.req0_wr_data = q0[0].wd;
    end
    if (q1.size() > 0) begin
      ifa.req1_rd_wr = q1[0].rd_wr; ifa.req1_addr = q1[0].addr; ifa.req1_wr_data = q1[0].wd;
    end
  end

  // ---------------- observation logs (actual DUT events) -------------------
  int   acc_port[$];
  int   acc_cyc[$];
  int   rsp_port_log[$];
  int   rsp_data_log[$];
  int   rsp_cyc_log[$];
  int   en_rdwr_log[$];

  task automatic clear_logs();
    acc_port.delete(); acc_cyc.delete();
    rsp_port_log.delete(); rsp_data_log.delete(); rsp_cyc_log.delete();
    en_rdwr_log.delete();
  endtask

  // ---------------- timeline reference model + compare ---------------------
  // cyc counts cycles; the model remembers only when the arbiter becomes free
  // again, in which cycle the mem command appears and in which cycle the
  // response pulses, plus its own copy of memory contents.
  int            cyc = 0;
  int            free_at = 0;
  int            issue_cyc = -1;
  int            rsp_cyc = -1;
  bit            prio = 1'b0;      // port that wins a tie
  bit            rsp_port = 1'b0;
  bit            rst_prev = 1'b1;  // reset value sampled at the last edge
  logic [DW-1:0] rsp_val;
  logic [DW-1:0] held0, held1;
  cmd_t          issued;
  logic [DW-1:0] mdl_mem [1<<AW];
  bit            idle, w0, w1, rcyc;

  always @(negedge clk) begin
    cyc++;
    if (rst_prev) begin
      free_at = cyc; issue_cyc = -1; rsp_cyc = -1; prio = 1'b0;
      held0 = '0; held1 = '0;
      foreach (mdl_mem[i]) mdl_mem[i] = '1;
      check("rst_mem_rd_wr",   32'(ifa.mem_rd_wr),   32'(0));
      check("rst_mem_addr",    32'(ifa.mem_addr),    32'(0));
      check("rst_mem_wr_data", 32'(ifa.mem_wr_data), 32'(0));
    end
    rcyc = (cyc == rsp_cyc);
    if (rcyc) begin
      if (rsp_port) held1 = rsp_val;
      else          held0 = rsp_val;
    end
    idle = (cyc >= free_at);
    w0 = idle && !reset && ifa.req0_valid && (!ifa.req1_valid || !prio);
    w1 = idle && !reset && ifa.req1_valid && (!ifa.req0_valid ||  prio);

    check("req0_ready", 32'(ifa.req0_ready), 32'(w0));
    check("req1_ready", 32'(ifa.req1_ready), 32'(w1));
    check("busy",       32'(ifa.busy),       32'(!idle));
    check("mem_enable", 32'(ifa.mem_enable), 32'(cyc == issue_cyc));
    if (cyc == issue_cyc) begin
      check("mem_rd_wr",   32'(ifa.mem_rd_wr),   32'(issued.rd_wr));
      check("mem_addr",    32'(ifa.mem_addr),    32'(issued.addr));
      check("mem_wr_data", 32'(ifa.mem_wr_data), 32'(issued.wd));
    end
    check("rsp0_valid", 32'(ifa.rsp0_valid), 32'(rcyc && !rsp_port));
    check("rsp1_valid", 32'(ifa.rsp1_valid), 32'(rcyc &&  rsp_port));
    check("rsp0_data",  32'(ifa.rsp0_data),  32'(held0));
    check("rsp1_data",  32'(ifa.rsp1_data),  32'(held1));

    hs0 = (ifa.req0_valid === 1'b1) && (ifa.req0_ready === 1'b1);
    hs1 = (ifa.req1_valid === 1'b1) && (ifa.req1_ready === 1'b1);
    if (hs0) begin acc_port.push_back(0); acc_cyc.push_back(cyc); end
    if (hs1) begin acc_port.push_back(1); acc_cyc.push_back(cyc); end
    if (ifa.rsp0_valid === 1'b1) begin
      rsp_port_log.push_back(0); rsp_data_log.push_back(int'(ifa.rsp0_data)); rsp_cyc_log.push_back(cyc);
    end
    if (ifa.rsp1_valid === 1'b1) begin
      rsp_port_log.push_back(1); rsp_data_log.push_back(int'(ifa.rsp1_data)); rsp_cyc_log.push_back(cyc);
    end
    if (ifa.mem_enable === 1'b1) en_rdwr_log.push_back(int'(ifa.mem_rd_wr));

    // Accept at the coming edge: the mem command shows in the next cycle;
    // a write frees the arbiter one cycle later, a read responds
    // 1+RD_LATENCY cycles after the command cycle.
    if (w0 || w1) begin
      issued    = w1 ? mk(ifa.req1_rd_wr, ifa.req1_addr, ifa.req1_wr_data)
                     : mk(ifa.req0_rd_wr, ifa.req0_addr, ifa.req0_wr_data);
      issue_cyc = cyc + 1;
      prio      = !w1;
      if (issued.rd_wr) begin
        rsp_cyc  = cyc + 2 + LAT_A;
        free_at  = rsp_cyc;
        rsp_port = w1;
        rsp_val  = mdl_mem[issued.addr];
      end else begin
        free_at = cyc + 2;
        mdl_mem[issued.addr] = issued.wd;
      end
    end
    rst_prev = reset;
  end

  // ---------------- helpers ------------------------------------------------
  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0 || cyc < free_at || ifa.busy !== 1'b0) && n < 300) begin
      @(posedge clk); #2;
      n++;
    end
    check({name, "_drain_in_time"}, 32'(n < 300), 32'(1));
    repeat (2) @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    @(posedge clk); #2;
    reset = 1'b1;
    q0.delete(); q1.delete();
    repeat (2) begin @(posedge clk); #2; end
    reset = 1'b0;
  endtask

  task automatic b_cmd(input logic rd_wr, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    bit ok;
    @(posedge clk); #2;
    ifb.req0_valid = 1'b1; ifb.req0_rd_wr = rd_wr; ifb.req0_addr = addr; ifb.req0_wr_data = wd;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (ifb.req0_ready === 1'b1) ok = 1'b1;
    end
    check("s6_ready_seen", 32'(ok), 32'(1));
  endtask

  function automatic cmd_t rand_cmd();
    return mk(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom));
  endfunction

  // ---------------- stimulus -----------------------------------------------
  initial begin
    int n;
    ifb.req0_valid = 1'b0; ifb.req0_rd_wr = 1'b0; ifb.req0_addr = '0; ifb.req0_wr_data = '0;
    ifb.req1_valid = 1'b0; ifb.req1_rd_wr = 1'b0; ifb.req1_addr = '0; ifb.req1_wr_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy",       32'(ifa.busy),       32'(0));
    check("reset_mem_enable", 32'(ifa.mem_enable), 32'(0));
    check("reset_rsp0_data",  32'(ifa.rsp0_data),  32'(0));
    check("reset_b_busy",     32'(ifb.busy),       32'(0));
    @(posedge clk); #2;
    reset = 1'b0;

    // 1: port 0 reads addr 3 -> 8'hFF, 4 cycles after the accept
    clear_logs();
    q0.push_back(mk(1'b1, 4'd3, 8'h00));
    wait_idle("s1");
    check("s1_acc_count", 32'(acc_port.size()),     32'(1));
    check("s1_rsp_count", 32'(rsp_port_log.size()), 32'(1));
    if (acc_cyc.size() == 1 && rsp_port_log.size() == 1) begin
      check("s1_rsp_port",    32'(rsp_port_log[0]),              32'(0));
      check("s1_rsp_data",    32'(rsp_data_log[0]),              32'(8'hFF));
      check("s1_rsp_latency", 32'(rsp_cyc_log[0] - acc_cyc[0]),  32'(4));
    end

    // 2: port 1 writes 8'h5A to addr 7 then reads it back
    clear_logs();
    q1.push_back(mk(1'b0, 4'd7, 8'h5A));
    q1.push_back(mk(1'b1, 4'd7, 8'h00));
    wait_idle("s2");
    check("s2_enable_pulses", 32'(en_rdwr_log.size()), 32'(2));
    if (en_rdwr_log.size() == 2) begin
      check("s2_first_rd_wr",  32'(en_rdwr_log[0]), 32'(0));
      check("s2_second_rd_wr", 32'(en_rdwr_log[1]), 32'(1));
    end
    check("s2_rsp_count", 32'(rsp_port_log.size()), 32'(1));
    if (rsp_port_log.size() == 1) begin
      check("s2_rsp_port", 32'(rsp_port_log[0]), 32'(1));
      check("s2_rsp_data", 32'(rsp_data_log[0]), 32'(8'h5A));
    end

    // 3: both ports continuously valid -> grants alternate 0,1,0,1,0,1
    apply_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_cmd());
      q1.push_back(rand_cmd());
    end
    wait_idle("s3");
    check("s3_grant_count", 32'(acc_port.size()), 32'(6));
    if (acc_port.size() == 6)
      for (int i = 0; i < 6; i++) check("s3_grant_order", 32'(acc_port[i]), 32'(i % 2));

    // 4: port 0 write and port 1 read of addr 2 arrive together
    apply_reset();
    clear_logs();
    q0.push_back(mk(1'b0, 4'd2, 8'h11));
    q1.push_back(mk(1'b1, 4'd2, 8'h00));
    wait_idle("s4");
    check("s4_grant_count", 32'(acc_port.size()), 32'(2));
    if (acc_port.size() == 2) begin
      check("s4_first_grant",  32'(acc_port[0]), 32'(0));
      check("s4_second_grant", 32'(acc_port[1]), 32'(1));
    end
    check("s4_rsp_count", 32'(rsp_port_log.size()), 32'(1));
    if (rsp_port_log.size() == 1) check("s4_rsp_data", 32'(rsp_data_log[0]), 32'(8'h11));

    // 5: reset during RD_WAIT drops the read without a response
    apply_reset();
    clear_logs();
    q0.push_back(mk(1'b1, 4'd3, 8'h00));
    n = 0;
    while (acc_port.size() == 0 && n < 50) begin @(posedge clk); #2; n++; end
    check("s5_accept_in_time", 32'(n < 50), 32'(1));
    @(posedge clk); #2;                     // RD_WAIT cycle
    check("s5_busy_before_reset", 32'(ifa.busy), 32'(1));
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("s5_busy_after_reset",   32'(ifa.busy),       32'(0));
    check("s5_enable_after_reset", 32'(ifa.mem_enable), 32'(0));
    check("s5_rsp0_after_reset",   32'(ifa.rsp0_valid), 32'(0));
    @(posedge clk); #2;
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("s5_no_rsp_pulse", 32'(rsp_port_log.size()), 32'(0));
    clear_logs();
    q0.push_back(mk(1'b1, 4'd3, 8'h00));
    wait_idle("s5b");
    check("s5_rsp_count", 32'(rsp_port_log.size()), 32'(1));
    if (acc_cyc.size() == 1 && rsp_port_log.size() == 1) begin
      check("s5_rsp_data",    32'(rsp_data_log[0]),             32'(8'hFF));
      check("s5_rsp_latency", 32'(rsp_cyc_log[0] - acc_cyc[0]), 32'(4));
    end

    // 6: RD_LATENCY=3 instance: write C3 to addr 5, read it back
    b_cmd(1'b0, 4'd5, 8'hC3);
    @(posedge clk); #2;
    ifb.req0_valid = 1'b0;
    repeat (3) @(posedge clk);
    b_cmd(1'b1, 4'd5, 8'h00);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #2;
      ifb.req0_valid = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        check("s6_issue_enable", 32'(ifb.mem_enable), 32'(1));
        check("s6_issue_rd_wr",  32'(ifb.mem_rd_wr),  32'(1));
        check("s6_issue_addr",   32'(ifb.mem_addr),   32'(5));
      end
      if (k < 5) begin
        check("s6_busy_in_flight", 32'(ifb.busy),       32'(1));
        check("s6_no_early_rsp",   32'(ifb.rsp0_valid), 32'(0));
      end else begin
        check("s6_rsp_valid_at_5", 32'(ifb.rsp0_valid), 32'(1));
        check("s6_rsp_data",       32'(ifb.rsp0_data),  32'(8'hC3));
        check("s6_rsp1_quiet",     32'(ifb.rsp1_valid), 32'(0));
        check("s6_busy_done",      32'(ifb.busy),       32'(0));
      end
    end

    // Randomised traffic with occasional one-cycle resets
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      @(posedge clk); #2;
      if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back(rand_cmd());
      if (q1.size() < 2 && $urandom_range(0, 3) == 0) q1.push_back(rand_cmd());
      if ($urandom_range(0, 199) == 0) begin
        reset = 1'b1;
        q0.delete(); q1.delete();
      end else begin
        reset = 1'b0;
      end
    end
    reset = 1'b0;
    wait_idle("rand");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
